// File: rtl/dpram_pkg.sv
// Shared types and sizing helpers for the initialised dual-port RAM.
package dpram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int byte_cnt(input int width);
    return width / 8;
  endfunction

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dpram_clear_ctl.sv
// Clear engine: walks every word once, writing the init pattern, after reset or on request.
module dpram_clear_ctl
  import dpram_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int CW    = cnt_width(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          busy,
  output logic          clr_we,
  output logic [CW-1:0] clr_addr
);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        // a new request mid-run restarts the sweep from word 0
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == CW'(WORDS - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/dualportram_init.sv
// Simple dual-port RAM with byte enables, read-valid strobe, optional output register,
// selectable read-during-write behaviour and a self-clearing engine.
module dualportram_init
  import dpram_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 10,
  parameter int               WORDS      = 1024,
  parameter int               OUT_REG    = 0,
  parameter int               RDW_MODE   = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          length,
  input  logic [31:0]          raddress,
  input  logic [31:0]          waddress,
  input  logic [WIDTH-1:0]     din,
  input  logic [WIDTH/8-1:0]   be,
  input  logic                 we,
  input  logic                 re,
  output logic [WIDTH-1:0]     dout,
  output logic                 dvalid,
  input  logic                 clear,
  output logic                 busy
);

  localparam int NB     = byte_cnt(WIDTH);
  localparam int AW     = cnt_width(WORDS);
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic [WIDTH-1:0] mem [WORDS];

  logic [DEPTH-1:0] ra, wa;
  logic             r_in, w_in;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;

  assign length = 32'(WORDS);
  assign ra     = raddress[DEPTH-1:0];
  assign wa     = waddress[DEPTH-1:0];
  assign r_in   = 32'(ra) < WORDS;
  assign w_in   = 32'(wa) < WORDS;

  logic unused_addr_hi;
  assign unused_addr_hi = ^{raddress[31:DEPTH], waddress[31:DEPTH]};

  dpram_clear_ctl #(.WORDS(WORDS), .CW(AW)) u_clr (
    .clk      (clk),
    .rst      (reset),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Clear engine owns the write port while running; user writes are dropped.
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NB-1:0]    wr_be;

  always_comb begin
    wr_addr = wa[AW-1:0];
    wr_data = din;
    wr_be   = '0;
    if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end else if (we && w_in) begin
      wr_be = be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end

  logic             rd_ok;
  logic [WIDTH-1:0] rd_word;

  assign rd_ok = re && !busy;

  always_comb begin
    rd_word = r_in ? mem[ra[AW-1:0]] : '0;
    // forward the bytes being written this cycle to a same-address read
    if (RDW_MODE != 0 && !busy && we && w_in && (wa == ra)) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) rd_word[8*i +: 8] = din[8*i +: 8];
    end
  end

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] data_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_ok;
      if (rd_ok) data_pipe[1] <= rd_word;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign dout   = data_pipe[STAGES];
  assign dvalid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dualportram_init.sv
// Bench for dualportram_init: two instances (latency 1 / old-data, latency 2 / new-data)
// driven identically and checked every cycle against a word-level model.
module tb_dualportram_init;

  localparam logic [31:0] INIT = 32'hA5A5A5A5;
  localparam int          NW   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] raddress = '0, waddress = '0, din = '0;
  logic [3:0]  be = '0;
  logic        we = 1'b0, re = 1'b0, clear = 1'b0;

  logic [31:0] len_a, len_b, dout_a, dout_b;
  logic        dv_a, dv_b, busy_a, busy_b;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  dualportram_init #(.WIDTH(32), .DEPTH(5), .WORDS(NW), .OUT_REG(0), .RDW_MODE(0),
                     .INIT_VALUE(INIT)) dut_a (
    .clk(clk), .reset(reset), .length(len_a), .raddress(raddress), .waddress(waddress),
    .din(din), .be(be), .we(we), .re(re), .dout(dout_a), .dvalid(dv_a),
    .clear(clear), .busy(busy_a));

  dualportram_init #(.WIDTH(32), .DEPTH(5), .WORDS(NW), .OUT_REG(1), .RDW_MODE(1),
                     .INIT_VALUE(INIT)) dut_b (
    .clk(clk), .reset(reset), .length(len_b), .raddress(raddress), .waddress(waddress),
    .din(din), .be(be), .we(we), .re(re), .dout(dout_b), .dvalid(dv_b),
    .clear(clear), .busy(busy_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: index 0 = latency 1 / old data, index 1 = latency 2 / new data.
  logic [31:0] mmem [2][NW];
  int          rem [2];
  logic        iv [2][4];
  logic [31:0] idat [2][4];
  logic [31:0] e_dout [2];
  logic        e_dv [2], e_busy [2];
  int          cyc = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        rem[d] = NW; e_dout[d] = '0; e_dv[d] = 1'b0; e_busy[d] = 1'b1;
        for (int s = 0; s < 4; s++) iv[d][s] = 1'b0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        logic [4:0]  ra, wa;
        logic        bsy, rok, wok;
        logic [31:0] rd;
        int          s;
        ra  = raddress[4:0];
        wa  = waddress[4:0];
        bsy = rem[d] > 0;
        rok = re && !bsy;
        wok = we && !bsy && (wa < NW);
        rd  = (ra < NW) ? mmem[d][ra[3:0]] : 32'h0;
        if (d == 1 && wok && wa == ra)
          for (int i = 0; i < 4; i++) if (be[i]) rd[8*i +: 8] = din[8*i +: 8];
        iv[d][cyc % 4]   = rok;
        idat[d][cyc % 4] = rd;
        if (wok)
          for (int i = 0; i < 4; i++) if (be[i]) mmem[d][wa[3:0]][8*i +: 8] = din[8*i +: 8];
        if (bsy) begin
          if (clear) rem[d] = NW;
          else begin
            rem[d]--;
            if (rem[d] == 0) for (int k = 0; k < NW; k++) mmem[d][k] = INIT;
          end
        end else if (clear) begin
          rem[d] = NW;
        end
        s = (cyc - d) % 4;
        e_dv[d] = iv[d][s];
        if (iv[d][s]) e_dout[d] = idat[d][s];
        e_busy[d] = rem[d] > 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("a.busy",   {31'b0, busy_a}, {31'b0, e_busy[0]});
    chk("a.dvalid", {31'b0, dv_a},   {31'b0, e_dv[0]});
    chk("a.dout",   dout_a,          e_dout[0]);
    chk("b.busy",   {31'b0, busy_b}, {31'b0, e_busy[1]});
    chk("b.dvalid", {31'b0, dv_b},   {31'b0, e_dv[1]});
    chk("b.dout",   dout_b,          e_dout[1]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick();
    end
    chk(nm, n, 16);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; waddress = a; din = d; be = b;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick(); tick();
    chk("reset dout", dout_a, 32'h0);
    chk("reset busy", {31'b0, busy_a}, 32'h1);
    chk("length", len_b, 32'd16);
    reset = 1'b0;
    count_busy("init busy cycles");

    // full readback of the init pattern
    re = 1'b1;
    for (int i = 0; i < NW; i++) begin
      raddress = i;
      tick();
      if (i == 0) chk("init word0", dout_a, INIT);
    end
    re = 1'b0;

    // byte-enabled write plus an all-disabled write
    wr(3, 32'h11223344, 4'b0101);
    wr(3, 32'hFFFFFFFF, 4'b0000);
    re = 1'b1; raddress = 3;
    tick();
    re = 1'b0;
    chk("a byte merge", dout_a, 32'hA522A544);
    tick();
    chk("b byte merge", dout_b, 32'hA522A544);

    // read-during-write on the same address
    we = 1'b1; waddress = 5; din = 32'hDEADBEEF; be = 4'hF;
    re = 1'b1; raddress = 5;
    tick();
    we = 1'b0; re = 1'b0;
    chk("a rdw old", dout_a, INIT);
    tick();
    chk("b rdw new", dout_b, 32'hDEADBEEF);

    // pipelined back-to-back reads
    wr(0, 32'h10101010, 4'hF);
    wr(1, 32'h20202020, 4'hF);
    wr(2, 32'h30303030, 4'hF);
    re = 1'b1; raddress = 0; tick();
    chk("b lat2 cyc1 dv", {31'b0, dv_b}, 32'h0);
    raddress = 1; tick();
    chk("b lat2 word0", dout_b, 32'h10101010);
    raddress = 2; tick();
    chk("b lat2 word1", dout_b, 32'h20202020);
    chk("a lat1 word2", dout_a, 32'h30303030);
    re = 1'b0; tick();
    chk("b lat2 word2", dout_b, 32'h30303030);
    chk("a idle dv", {31'b0, dv_a}, 32'h0);
    tick();

    // clear with an accepted read, traffic during busy, then a restart
    clear = 1'b1; re = 1'b1; raddress = 5;
    tick();
    clear = 1'b0;
    chk("read on clear edge", dout_a, 32'hDEADBEEF);
    we = 1'b1; waddress = 0; din = 32'hFFFFFFFF; be = 4'hF; raddress = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy read dv", {31'b0, dv_a}, 32'h0);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy("restart busy cycles");
    we = 1'b0; re = 1'b0;
    re = 1'b1; raddress = 0; tick(); re = 1'b0;
    chk("a cleared word0", dout_a, INIT);
    tick();
    chk("b cleared word0", dout_b, INIT);

    // reset in the middle of a clear
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    chk("mid-clear reset dv", {31'b0, dv_b}, 32'h0);
    reset = 1'b0;
    count_busy("post-reset busy cycles");

    // out-of-range access
    wr(4, 32'h44444444, 4'hF);
    wr(20, 32'h99999999, 4'hF);
    re = 1'b1; raddress = 20; tick();
    chk("oor read data", dout_a, 32'h0);
    chk("oor read dv", {31'b0, dv_a}, 32'h1);
    raddress = 4; tick();
    re = 1'b0;
    chk("a word4 intact", dout_a, 32'h44444444);
    tick();
    chk("b word4 intact", dout_b, 32'h44444444);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dualportram_init.md
Name: dualportram_init

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Adds per-byte write enables, a read strobe with a data-valid flag, and an optional output register (1- or 2-cycle read latency).
- Adds a selectable read-during-write policy and a sequential clear engine that fills the memory with INIT_VALUE after reset or on request.
- Used as the backing store for arrays and buffers that must start in a known state.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 10, number of address bits used.
- WORDS, 1024, number of words; 1 <= WORDS <= 2**DEPTH.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data; 1 = read returns new (byte-merged) data.
- INIT_VALUE, 0, WIDTH-bit word written by the clear engine.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- length  out  32  constant WORDS.
- raddress  in  32  read address; bits [DEPTH-1:0] used.
- waddress  in  32  write address; bits [DEPTH-1:0] used.
- din  in  WIDTH  write data.
- be  in  WIDTH/8  byte enables; bit i gates din[8i+7:8i].
- we  in  1  write strobe.
- re  in  1  read strobe.
- dout  out  WIDTH  read data.
- dvalid  out  1  one-cycle pulse; dout holds the data for the accepted read.
- clear  in  1  start (or restart) the clear engine.
- busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (async assert):
  - dout=0, dvalid=0, pipeline registers=0.
  - FSM enters CLEAR with clear counter=0; busy=1 immediately.
  - Memory contents are not reset directly; the clear engine initialises them.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes INIT_VALUE (all bytes) to mem[cnt], then cnt++. After writing word WORDS-1, go to IDLE; busy falls on the following edge.
  - A full clear takes exactly WORDS cycles from reset deassertion or from the clear pulse.
  - IDLE: clear=1 -> CLEAR with cnt=0; busy=1 from the next edge.
  - clear=1 while in CLEAR restarts cnt at 0.
- While busy:
  - we and re are ignored; no memory update.
  - dvalid stays 0 and dout holds its last value.
  - A read already in the OUT_REG pipeline when clear is accepted still completes.
- Write (IDLE, we=1): for each i with be[i]=1, mem[waddress][byte i] <= din[byte i]. Bytes with be[i]=0 are unchanged. we with be=0 is a no-op.
- Read (IDLE, re=1) issued at edge t:
  - OUT_REG=0: dout updated and dvalid=1 at edge t+1.
  - OUT_REG=1: dout updated and dvalid=1 at edge t+2.
  - One read per cycle, fully pipelined; back-to-back reads give back-to-back dvalid.
  - dout holds between reads; dvalid is 0 on cycles with no read completing.
- Out-of-range addresses (address[DEPTH-1:0] >= WORDS): writes are dropped; reads return 0 with dvalid=1.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: old word.
  - RDW_MODE=1: old word with the enabled bytes replaced by din (forwarding mux).
- Different addresses in the same cycle are independent.
- Reset asserted mid-clear or mid-read aborts immediately: dvalid=0 and the clear restarts from 0 after deassertion.
- length is constant WORDS and is unaffected by reset.

Decomposition:
- Shared package dpram_pkg:
  - FSM state encoding (ST_IDLE, ST_CLEAR).
  - Function computing the byte count (WIDTH/8).
  - Function computing the counter width (clog2 of WORDS, minimum 1).
- One natural sub-module, dpram_clear_ctl:
  - Contains the FSM and address counter.
  - Outputs busy, clear write enable and clear address.
- The top module muxes the clear port onto the write port and holds the array, byte-merge logic, RDW forwarding and the output pipeline.

Test Plan:
1. Reset then release; WORDS=16, INIT_VALUE=32'hA5A5A5A5 -> busy high for exactly 16 cycles. Then reading addresses 0..15 returns A5A5A5A5 with dvalid one cycle after each re (OUT_REG=0).
2. After init, write 32'h11223344 to addr 3 with be=4'b0101, then read addr 3 -> dout=32'hA522A544.
3. RDW_MODE=1: same cycle we addr 5, din=32'hDEADBEEF, be=4'hF, re addr 5 -> dout=32'hDEADBEEF. RDW_MODE=0 under the same stimulus -> A5A5A5A5.
4. OUT_REG=1: re on addresses 0,1,2 in consecutive cycles -> dvalid high on cycles t+2..t+4, data in issue order.
5. Pulse clear, assert we/re during busy -> no memory change, dvalid=0. Pulse clear again mid-run -> busy lasts a further 16 cycles from the restart.
6. Assert reset at cycle 8 of a clear, release -> busy for 16 full cycles. Read of addr 20 with WORDS=16, DEPTH=5 -> dout=0, dvalid=1. A write to addr 20 leaves addr 4 unchanged.
